fm_discrim_mc: RTL and testbench

- Multi-channel, parametrised FM discriminator front end. Computes y[n] = x[n]·conj(x[n−LAG]) per channel on time-interleaved complex IQ samples.
- Placed between the channeliser/decimator output stream and the CORDIC angle stage. The angle of y is the instantaneous frequency.
- Adds the following over the single-channel lag-1 discriminator:
  - per-channel history
  - configurable lag
  - scaling with saturation
  - a registered two-stage pipeline with full backpressure
  - channel/warm-up sideband on the output

---
 rtl/fm_discrim_mc_if.sv | 25 ++
 rtl/fm_discrim_mc.sv | 122 ++++++++++++
 tb/tb_fm_discrim_mc.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_discrim_mc_if.sv
// AXI-stream style bus bundle for the FM discriminator: input sample stream and output product stream.
interface fm_discrim_mc_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CHW   = 2
);
  logic [2*IN_W-1:0]  s00_axis_tdata;
  logic               s00_axis_tvalid;
  logic               s00_axis_tlast;
  logic               s00_axis_tready;
  logic [2*OUT_W-1:0] m00_axis_tdata;
  logic               m00_axis_tvalid;
  logic               m00_axis_tready;
  logic               m00_axis_tlast;
  logic [CHW:0]       m00_axis_tuser;

  modport slave (
    input  s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast, m00_axis_tready,
    output s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser
  );
  modport master (
    output s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast, m00_axis_tready,
    input  s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser
  );
endinterface

// File: rtl/fm_discrim_mc.sv
// Multi-channel FM discriminator front end: y = x[n]*conj(x[n-LAG]) per interleaved channel,
// two registered stages with full backpressure, scaled and saturated output.
module fm_discrim_mc #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int NCH   = 4,
  parameter int LAG   = 1,
  parameter int SHIFT = 1,
  parameter int CHW   = (NCH > 1 ? $clog2(NCH) : 1)
) (
  input  logic           s00_axis_aclk,
  input  logic           s00_axis_areset,
  input  logic           hist_clr,
  fm_discrim_mc_if.slave axis
);
  localparam int PW  = (LAG > 1) ? $clog2(LAG) : 1;
  localparam int QW  = $clog2(LAG + 1);
  localparam int HN  = NCH * LAG;
  localparam int HIW = (HN > 1) ? $clog2(HN) : 1;
  localparam int PRW = 2 * IN_W;
  localparam int SW  = 2 * IN_W + 1;
  localparam int WW  = ((SW > OUT_W) ? SW : OUT_W) + 1;
  localparam logic signed [WW-1:0] MAXV = (WW'(1) <<< (OUT_W - 1)) - WW'(1);
  localparam logic signed [WW-1:0] MINV = ~MAXV;

  logic clk, rst;
  assign clk = s00_axis_aclk;
  assign rst = s00_axis_areset;

  logic en, acc, warm;
  logic [CHW-1:0] ch_q;
  logic [PW-1:0]  ptr_q    [NCH];
  logic [QW-1:0]  primed_q [NCH];
  logic signed [IN_W-1:0] hist_re_q [HN];
  logic signed [IN_W-1:0] hist_im_q [HN];
  logic [HIW-1:0] hidx;
  logic signed [IN_W-1:0] a, b, c, d;
  logic signed [PRW-1:0] ac_q, bd_q, bc_q, ad_q;
  logic v1_q, l1_q, ovld_q, olast_q;
  logic [CHW:0] u1_q, ouser_q;
  logic [2*OUT_W-1:0] odata_q;
  logic signed [SW-1:0] sre, sim;

  assign en  = !ovld_q || axis.m00_axis_tready;
  assign acc = axis.s00_axis_tvalid && en;
  assign axis.s00_axis_tready = en;
  assign axis.m00_axis_tvalid = ovld_q;
  assign axis.m00_axis_tdata  = odata_q;
  assign axis.m00_axis_tlast  = olast_q;
  assign axis.m00_axis_tuser  = ouser_q;

  // A clear in the same cycle as a beat makes that beat warm even if history was primed.
  always_comb begin
    hidx = HIW'(int'(ch_q) * LAG + int'(ptr_q[ch_q]));
    warm = hist_clr || (primed_q[ch_q] != QW'(LAG));
    a    = axis.s00_axis_tdata[IN_W-1:0];
    b    = axis.s00_axis_tdata[2*IN_W-1:IN_W];
    c    = warm ? '0 : hist_re_q[hidx];
    d    = warm ? '0 : hist_im_q[hidx];
    sre  = SW'(ac_q) + SW'(bd_q);
    sim  = SW'(bc_q) - SW'(ad_q);
  end

  function automatic logic [OUT_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [WW-1:0] w;
    w = WW'(v >>> SHIFT);
    if (w > MAXV)      sat = MAXV[OUT_W-1:0];
    else if (w < MINV) sat = MINV[OUT_W-1:0];
    else               sat = w[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (acc) begin
      hist_re_q[hidx] <= a;
      hist_im_q[hidx] <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hist_clr) begin
      for (int i = 0; i < NCH; i++) begin
        ptr_q[i]    <= '0;
        primed_q[i] <= '0;
      end
    end else if (acc) begin
      ptr_q[ch_q] <= (ptr_q[ch_q] == PW'(LAG - 1)) ? '0 : ptr_q[ch_q] + PW'(1);
      if (primed_q[ch_q] != QW'(LAG)) primed_q[ch_q] <= primed_q[ch_q] + QW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q    <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      u1_q    <= '0;
      ac_q    <= '0;
      bd_q    <= '0;
      bc_q    <= '0;
      ad_q    <= '0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
      ouser_q <= '0;
      odata_q <= '0;
    end else if (en) begin
      v1_q    <= acc;
      l1_q    <= axis.s00_axis_tlast;
      u1_q    <= {warm, ch_q};
      ac_q    <= PRW'(a) * PRW'(c);
      bd_q    <= PRW'(b) * PRW'(d);
      bc_q    <= PRW'(b) * PRW'(c);
      ad_q    <= PRW'(a) * PRW'(d);
      ovld_q  <= v1_q;
      olast_q <= l1_q;
      ouser_q <= u1_q;
      odata_q <= {sat(sim), sat(sre)};
      // tlast resynchronises the channel tag regardless of where in the rotation it lands
      if (acc)
        ch_q <= (axis.s00_axis_tlast || ch_q == CHW'(NCH - 1)) ? '0 : ch_q + CHW'(1);
    end
  end
endmodule

// File: tb/tb_fm_discrim_mc.sv
// Randomised scoreboard bench for fm_discrim_mc: a queue-based reference model predicts each output beat.
module tb_fm_discrim_mc;
  localparam int IN_W  = 16;
  localparam int OUT_W = 24;
  localparam int NCH   = 3;
  localparam int LAG   = 2;
  localparam int SHIFT = 1;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int HW    = 2*OUT_W + CHW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hist_clr = 1'b0;
  always #5 clk = ~clk;

  fm_discrim_mc_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CHW(CHW)) bus ();

  fm_discrim_mc #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH), .LAG(LAG), .SHIFT(SHIFT)) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .hist_clr       (hist_clr),
    .axis           (bus)
  );

  typedef struct {
    logic [2*OUT_W-1:0] data;
    logic [CHW:0]       user;
    logic               last;
    int                 cyc;
    bit                 chk_lat;
  } exp_t;

  typedef struct { int re; int im; } samp_t;

  exp_t  sb[$];
  samp_t hq[NCH][$];
  int    mch = 0;
  int    cyc = 0;
  int    checks = 0;
  int    passed = 0;
  int    rmode = 0;
  int    stall = 0;
  bit    lat_mode = 0;
  bit    rst_seen = 1;
  bit    hold_v = 0;
  logic [HW-1:0] held;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic longint satf(input longint v);
    longint mx;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  function automatic int rnd_comp();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
  end

  // Downstream ready driver; rmode 2 leaves tready under direct control of the main sequence.
  initial begin
    bus.m00_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin
        bus.m00_axis_tready = 1'b0;
        stall--;
      end else if (rmode == 0) bus.m00_axis_tready = 1'b1;
      else if (rmode == 1) bus.m00_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor and reference model: evaluated mid-cycle, when every handshake signal is settled.
  always @(negedge clk) begin
    logic [HW-1:0] cur_o;
    cur_o = {bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tuser, bus.m00_axis_tdata};
    if (rst_seen)
      chk(cur_o == '0, "reset_outputs", longint'(cur_o), 0);
    if (hold_v && !rst_seen)
      chk(cur_o == held, "stall_hold", longint'(cur_o), longint'(held));
    hold_v = !rst && bus.m00_axis_tvalid && !bus.m00_axis_tready;
    held   = cur_o;
    chk(bus.s00_axis_tready == (!bus.m00_axis_tvalid || bus.m00_axis_tready), "s_tready",
        longint'(bus.s00_axis_tready), longint'(!bus.m00_axis_tvalid || bus.m00_axis_tready));

    if (rst) begin
      sb.delete();
      for (int i = 0; i < NCH; i++) hq[i].delete();
      mch = 0;
    end else begin
      if (bus.m00_axis_tvalid && bus.m00_axis_tready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_output", longint'(bus.m00_axis_tdata), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(bus.m00_axis_tdata == e.data, "tdata", longint'(bus.m00_axis_tdata), longint'(e.data));
          chk(bus.m00_axis_tuser == e.user, "tuser", longint'(bus.m00_axis_tuser), longint'(e.user));
          chk(bus.m00_axis_tlast == e.last, "tlast", longint'(bus.m00_axis_tlast), longint'(e.last));
          if (e.chk_lat) chk(cyc - e.cyc == 2, "latency", cyc - e.cyc, 2);
        end
      end
      if (bus.s00_axis_tvalid && bus.s00_axis_tready) begin
        int a, b, c, d;
        bit warm;
        longint re, im;
        exp_t e;
        samp_t s;
        a = int'($signed(bus.s00_axis_tdata[IN_W-1:0]));
        b = int'($signed(bus.s00_axis_tdata[2*IN_W-1:IN_W]));
        warm = hist_clr || (hq[mch].size() < LAG);
        c = warm ? 0 : hq[mch][0].re;
        d = warm ? 0 : hq[mch][0].im;
        s.re = a;
        s.im = b;
        hq[mch].push_back(s);
        if (hq[mch].size() > LAG) void'(hq[mch].pop_front());
        re = satf((longint'(a) * c + longint'(b) * d) >>> SHIFT);
        im = satf((longint'(b) * c - longint'(a) * d) >>> SHIFT);
        e.data    = {im[OUT_W-1:0], re[OUT_W-1:0]};
        e.user    = {warm, CHW'(mch)};
        e.last    = bus.s00_axis_tlast;
        e.cyc     = cyc;
        e.chk_lat = lat_mode;
        sb.push_back(e);
        mch = bus.s00_axis_tlast ? 0 : (mch + 1) % NCH;
      end
      if (hist_clr)
        for (int i = 0; i < NCH; i++) hq[i].delete();
    end
  end

  task automatic idle(input int n);
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input int re, input int im, input bit last, input bit clr);
    int n;
    bit acc;
    n = 0;
    bus.s00_axis_tdata  = {im[IN_W-1:0], re[IN_W-1:0]};
    bus.s00_axis_tvalid = 1'b1;
    bus.s00_axis_tlast  = last;
    hist_clr = clr;
    forever begin
      @(negedge clk);
      acc = bus.s00_axis_tready;
      @(posedge clk); #1;
      hist_clr = 1'b0;
      if (acc || rst) break;
      n++;
      if (n > 100) begin
        chk(1'b0, "send_timeout", n, 100);
        break;
      end
    end
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(sb.size() == 0, "drain", sb.size(), 0);
  endtask

  initial begin
    bus.s00_axis_tdata  = '0;
    bus.s00_axis_tvalid = 1'b0;
    bus.s00_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed rotation and full-scale saturation, downstream always ready.
    lat_mode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      send(100, 0, 1'b0, 1'b0);
      send(0, 100, 1'b0, 1'b0);
      send(-100, 0, 1'b1, 1'b0);
    end
    for (int r = 0; r < 3; r++)
      for (int ch = 0; ch < NCH; ch++)
        send(-32768, -32768, ch == NCH - 1, 1'b0);
    for (int ch = 0; ch < NCH; ch++) send(32767, 32767, ch == NCH - 1, 1'b0);
    for (int ch = 0; ch < NCH; ch++) send(-32768, 32767, ch == NCH - 1, 1'b0);
    drain();
    lat_mode = 1'b0;

    // Random traffic with random gaps, random backpressure, a 5-cycle stall and stray clears/tlasts.
    rmode = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (i == 80) stall = 5;
      send(rnd_comp(), rnd_comp(), $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
    end
    rmode = 0;
    drain();

    // Misaligned tlast, clear pulse, then reset with two beats stuck in the pipeline.
    send(500, 200, 1'b0, 1'b0);
    send(-300, 700, 1'b1, 1'b0);
    hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_comp(), rnd_comp(), 1'b0, 1'b0);
    drain();
    rmode = 2;
    bus.m00_axis_tready = 1'b0;
    send(1234, -567, 1'b0, 1'b0);
    send(-890, 321, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.m00_axis_tready = 1'b1;
    rmode = 0;
    for (int r = 0; r < 2; r++)
      for (int ch = 0; ch < NCH; ch++) send(rnd_comp(), rnd_comp(), ch == NCH - 1, 1'b0);
    drain();
    idle(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
